sram_tp_fifo_ctrl: RTL
======================

// Module: sram_tp_fifo_ctrl
// PURPOSE
//  FIFO controller that drives the write and read ports of an external two-port
//  bit-enable SRAM (ADR words x DAT_WD, 1-cycle registered read, rd_dat=0 when rd_ena low).
//  Valid/ready push side in, first-word-fall-through valid/ready pop side out.
//  Generic line/CU buffering between pipeline stages; the SRAM macro stays outside the block.
// PARAMETERS
//  ADR_WD  5   SRAM address width; SRAM depth DEPTH = 1<<ADR_WD
//  DAT_WD  8   data width
//  COL_WD  8   SRAM bit-enable column width; NCOL = DAT_WD/COL_WD (integer, >=1)
// PORTS
//  clk          in   1            clock
//  rstn         in   1            async reset, active low
//  push_val     in   1            push request
//  push_rdy     out  1            push accepted when push_val&push_rdy
//  push_dat     in   DAT_WD       push data
//  pop_val      out  1            head word valid
//  pop_rdy      in   1            pop accepted when pop_val&pop_rdy
//  pop_dat      out  DAT_WD       head word
//  level        out  ADR_WD+2     total words held (SRAM + in-flight + output buffer)
//  flush        in   1            sync flush (only with SRAM_FIFO_FLUSH_EN)
//  sram_wr_ena  out  NCOL         SRAM column write enables
//  sram_wr_adr  out  ADR_WD       SRAM write address
//  sram_wr_dat  out  DAT_WD       SRAM write data
//  sram_rd_ena  out  1            SRAM read enable
//  sram_rd_adr  out  ADR_WD       SRAM read address
//  sram_rd_dat  in   DAT_WD       SRAM read data, valid cycle after sram_rd_ena
// BEHAVIOUR
//  - Reset (async, rstn=0): wr_ptr=rd_ptr=0, mem_cnt=0, inflight=0, ob_cnt=0;
//    push_rdy=0 during reset, pop_val=0, pop_dat=0, level=0, sram_wr_ena=0, sram_rd_ena=0,
//    sram_*_adr=0. SRAM contents not cleared; stale words never read.
//  - Reset mid-operation: all held words lost, no partial state survives.
//  - push_rdy = (mem_cnt != DEPTH), registered-state only, no combinational pop path.
//  - Push fire: sram_wr_ena={NCOL{1'b1}}, sram_wr_adr=wr_ptr, sram_wr_dat=push_dat,
//    combinational to the SRAM same cycle; wr_ptr+1 mod DEPTH (natural wrap); else wr_ena=0.
//  - mem_cnt counts written-not-yet-read words; increments the cycle after the write,
//    so an address is never read in the cycle it is written (no same-address R/W).
//  - Output buffer: 2-entry FIFO (ob). pop_val=(ob_cnt!=0), pop_dat=ob head register.
//  - Read issue: sram_rd_ena=1 when mem_cnt!=0 && (ob_cnt + inflight - pop_fire) < 2;
//    sram_rd_adr=rd_ptr; rd_ptr+1 mod DEPTH; mem_cnt-1; inflight<=1 next cycle.
//  - inflight=1: sram_rd_dat captured into ob tail at end of that cycle; never dropped.
//  - Simultaneous push, read issue and pop in one cycle: all three take effect;
//    mem_cnt += push - read; ob_cnt += capture - pop.
//  - Latency: push at cycle N on empty FIFO -> rd_ena cycle N+1 -> pop_val cycle N+3.
//  - Throughput: sustained 1 push and 1 pop per cycle once primed; no bubbles.
//  - Full: mem_cnt==DEPTH -> push_rdy=0; capacity DEPTH+2 words total.
//  - Empty: level==0 -> pop_val=0; pop_rdy ignored, no underflow.
//  - level = mem_cnt + inflight + ob_cnt, registered.
// CONFIGURATION
//  - SRAM_FIFO_FLUSH_EN defined: flush port exists. flush=1 at a clock edge sets
//    pointers, counts, inflight, ob to reset values; push/pop in that cycle are
//    dropped (push_rdy forced 0, pop not counted); an in-flight read returning the
//    next cycle is discarded. pop_val=0 and level=0 the cycle after flush.
//  - Not defined: no flush port; only rstn clears state.
// TESTING
//  - Reset: rstn=0 with push_val=1 -> push_rdy=0, pop_val=0, level=0, sram_wr_ena=0.
//  - Single word: push 0xA5 cycle 0 on empty -> sram_rd_ena cycle 1, pop_val=1 and
//    pop_dat=0xA5 cycle 3, level 1 until popped.
//  - Fill: ADR_WD=5, pop_rdy=0, push 34 words 0..33 -> push_rdy=0 after mem_cnt=32,
//    level=34; then pop all -> 0..33 in order, level returns 0.
//  - Streaming: push_val=pop_rdy=1 for 200 cycles, incrementing data -> one pop per cycle
//    after priming, sequence intact across pointer wrap, level constant.
//  - Backpressure: random pop_rdy (50%) with continuous pushes -> no loss/duplication,
//    rd_ena never asserted when ob_cnt+inflight would exceed 2.
//  - Flush (SRAM_FIFO_FLUSH_EN): 10 words queued, flush during in-flight read -> next
//    cycle level=0, pop_val=0; push 0x3C afterwards pops 0x3C first.

Source files
------------

// File: rtl/sram_tp_fifo_ctrl.sv
// sram_tp_fifo_ctrl
//   Valid/ready FIFO controller around an external two-port bit-enable SRAM
//   with a 1-cycle registered read port. A 2-entry output buffer hides the
//   SRAM read latency, so the pop side behaves as first-word-fall-through.
//   Total capacity is DEPTH words in the SRAM plus 2 in the output buffer.
//   Optional synchronous flush port: define SRAM_FIFO_FLUSH_EN.
module sram_tp_fifo_ctrl #(
   parameter int unsigned ADR_WD = 5,
   parameter int unsigned DAT_WD = 8,
   parameter int unsigned COL_WD = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     push_val,
   output logic                     push_rdy,
   input  logic [DAT_WD-1:0]        push_dat,
   output logic                     pop_val,
   input  logic                     pop_rdy,
   output logic [DAT_WD-1:0]        pop_dat,
   output logic [ADR_WD+1:0]        level,
`ifdef SRAM_FIFO_FLUSH_EN
   input  logic                     flush,
`endif
   output logic [DAT_WD/COL_WD-1:0] sram_wr_ena,
   output logic [ADR_WD-1:0]        sram_wr_adr,
   output logic [DAT_WD-1:0]        sram_wr_dat,
   output logic                     sram_rd_ena,
   output logic [ADR_WD-1:0]        sram_rd_adr,
   input  logic [DAT_WD-1:0]        sram_rd_dat
);

   localparam int unsigned NCOL = DAT_WD / COL_WD;
   // mem_cnt value meaning every SRAM word holds unread data
   localparam logic [ADR_WD:0] FULL_CNT = {1'b1, {ADR_WD{1'b0}}};

   logic [ADR_WD-1:0] wr_ptr;
   logic [ADR_WD-1:0] rd_ptr;
   logic [ADR_WD:0]   mem_cnt;
   logic [ADR_WD:0]   mem_cnt_nxt;
   logic              inflight;
   logic              inflight_nxt;
   logic [1:0]        ob_cnt;
   logic [1:0]        ob_cnt_nxt;
   logic [ADR_WD+1:0] level_nxt;
   logic [DAT_WD-1:0] ob_mem [2];
   logic              ob_wr_idx;
   logic              ob_rd_idx;

   logic              flush_i;
   logic              push_fire;
   logic              pop_fire;
   logic              rd_issue;
   logic [2:0]        ob_occ;

`ifdef SRAM_FIFO_FLUSH_EN
   assign flush_i = flush;
`else
   assign flush_i = 1'b0;
`endif

   // Handshakes and read-issue decision; push_rdy depends on registered state only.
   always_comb begin
      push_rdy  = rstn & ~flush_i & (mem_cnt != FULL_CNT);
      push_fire = push_val & push_rdy;
      pop_val   = (ob_cnt != 2'd0);
      pop_fire  = pop_val & pop_rdy & ~flush_i;
      // Output-buffer slots already claimed once this cycle's pop is taken.
      ob_occ    = {1'b0, ob_cnt} + {2'b00, inflight} - {2'b00, pop_fire};
      rd_issue  = (mem_cnt != '0) & (ob_occ < 3'd2) & ~flush_i;
   end

   assign sram_wr_ena = {NCOL{push_fire}};
   assign sram_wr_adr = wr_ptr;
   assign sram_wr_dat = push_dat;
   assign sram_rd_ena = rd_issue;
   assign sram_rd_adr = rd_ptr;
   assign pop_dat     = ob_mem[ob_rd_idx];

   // Next-state counts; a push shows up in mem_cnt one cycle late, so a word is
   // never read in the cycle it is written.
   always_comb begin
      mem_cnt_nxt  = mem_cnt + {{ADR_WD{1'b0}}, push_fire} - {{ADR_WD{1'b0}}, rd_issue};
      inflight_nxt = rd_issue;
      ob_cnt_nxt   = ob_cnt + {1'b0, inflight} - {1'b0, pop_fire};
      if (flush_i) begin
         mem_cnt_nxt  = '0;
         inflight_nxt = 1'b0;
         ob_cnt_nxt   = '0;
      end
      level_nxt = {1'b0, mem_cnt_nxt}
                + {{(ADR_WD+1){1'b0}}, inflight_nxt}
                + {{ADR_WD{1'b0}}, ob_cnt_nxt};
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mem_cnt  <= '0;
         inflight <= 1'b0;
         ob_cnt   <= '0;
         level    <= '0;
      end else begin
         mem_cnt  <= mem_cnt_nxt;
         inflight <= inflight_nxt;
         ob_cnt   <= ob_cnt_nxt;
         level    <= level_nxt;
         if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push_fire) wr_ptr <= wr_ptr + ADR_WD'(1);
            if (rd_issue)  rd_ptr <= rd_ptr + ADR_WD'(1);
         end
      end
   end

   // Output buffer: returning SRAM word enters at the tail, pop advances the head.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ob_mem[0] <= '0;
         ob_mem[1] <= '0;
         ob_wr_idx <= 1'b0;
         ob_rd_idx <= 1'b0;
      end else if (flush_i) begin
         ob_wr_idx <= 1'b0;
         ob_rd_idx <= 1'b0;
      end else begin
         if (inflight) begin
            ob_mem[ob_wr_idx] <= sram_rd_dat;
            ob_wr_idx         <= ~ob_wr_idx;
         end
         if (pop_fire) ob_rd_idx <= ~ob_rd_idx;
      end
   end

   // Structural invariants of the read pipeline.
   a_ob_bound : assert property (@(posedge clk) disable iff (!rstn)
      ({1'b0, ob_cnt} + {2'b00, inflight}) <= 3'd2);
   a_mem_bound : assert property (@(posedge clk) disable iff (!rstn)
      mem_cnt <= FULL_CNT);
   a_no_same_adr : assert property (@(posedge clk) disable iff (!rstn)
      !(push_fire && rd_issue && (wr_ptr == rd_ptr)));

endmodule
